// File: rtl/seg7_display_ctrl.sv
// rtl/seg7_display_ctrl.sv - debug value selector and 8-digit multiplexed 7-segment driver
//
// Purpose:
//   Selects one 32-bit CPU debug value by display_op, snapshots it once per
//   full scan, and shows it as 8 hex digits on a common-anode display.
//   Runs on the undivided board clock so the display stays live whatever
//   the CPU clock is doing.
//
// Ports:
//   clk              board clock
//   rst_n            synchronous active-low reset
//   display_op       content select (0 pc, 1 ram word, 2 cycles, 3 jumps,
//                    4 branches, 5 taken branches, 6 addr:data, 7 syscall)
//   ram_display_addr RAM word address being viewed
//   ram_data         RAM read data at ram_display_addr
//   pc               current PC
//   cycle_cnt        total cycle counter
//   jmp_cnt          unconditional jump counter
//   br_cnt           conditional branch counter
//   br_taken_cnt     taken conditional branch counter
//   syscall_val      syscall display register
//   an               digit enables, active low, an[0] = least significant digit
//   seg              segments {dp,g,f,e,d,c,b,a}, active low

module seg7_display_ctrl #(
    parameter int SCAN_DIV      = 100000,
    parameter bit BLANK_LEADING = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [2:0]  display_op,
    input  logic [9:0]  ram_display_addr,
    input  logic [31:0] ram_data,
    input  logic [31:0] pc,
    input  logic [31:0] cycle_cnt,
    input  logic [31:0] jmp_cnt,
    input  logic [31:0] br_cnt,
    input  logic [31:0] br_taken_cnt,
    input  logic [31:0] syscall_val,
    output logic [7:0]  an,
    output logic [7:0]  seg
);

    localparam int             PW        = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0]  PRESC_MAX = PW'(SCAN_DIV - 1);
    localparam logic [2:0]     OP_ADDR   = 3'b110;

    logic [PW-1:0] presc_q, presc_d;
    logic [2:0]    idx_q, idx_d;
    logic [31:0]   frame_q, frame_d;
    logic          frame_dp_q, frame_dp_d;
    logic [2:0]    op_q;
    logic [7:0]    an_q, an_d;
    logic [7:0]    seg_q, seg_d;

    logic [31:0]   sel_val;
    logic          op_change;
    logic          term_cnt;
    logic [31:0]   frame_shifted;
    logic [3:0]    cur_nibble;
    logic          cur_blank;

    // Active-low {g,f,e,d,c,b,a} patterns for one hex digit.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0:    s = 7'b1000000;
            4'h1:    s = 7'b1111001;
            4'h2:    s = 7'b0100100;
            4'h3:    s = 7'b0110000;
            4'h4:    s = 7'b0011001;
            4'h5:    s = 7'b0010010;
            4'h6:    s = 7'b0000010;
            4'h7:    s = 7'b1111000;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0010000;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b0000011;
            4'hC:    s = 7'b1000110;
            4'hD:    s = 7'b0100001;
            4'hE:    s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    always_comb begin
        sel_val = pc;
        case (display_op)
            3'b000:  sel_val = pc;
            3'b001:  sel_val = ram_data;
            3'b010:  sel_val = cycle_cnt;
            3'b011:  sel_val = jmp_cnt;
            3'b100:  sel_val = br_cnt;
            3'b101:  sel_val = br_taken_cnt;
            3'b110:  sel_val = {6'b0, ram_display_addr, ram_data[15:0]};
            default: sel_val = syscall_val;
        endcase
    end

    assign op_change = (display_op != op_q);
    assign term_cnt  = (presc_q == PRESC_MAX);

    // Scan state. The frame only reloads when a scan starts over, either at
    // the natural 7->0 wrap or when the operator picks a new source; that way
    // every digit of one scan comes from the same snapshot. A new op wins
    // over a coincident terminal count so the new value appears immediately.
    always_comb begin
        presc_d    = presc_q;
        idx_d      = idx_q;
        frame_d    = frame_q;
        frame_dp_d = frame_dp_q;
        if (op_change) begin
            presc_d    = '0;
            idx_d      = 3'd0;
            frame_d    = sel_val;
            frame_dp_d = (display_op == OP_ADDR);
        end else if (term_cnt) begin
            presc_d = '0;
            idx_d   = idx_q + 3'd1;
            if (idx_q == 3'd7) begin
                frame_d    = sel_val;
                frame_dp_d = (display_op == OP_ADDR);
            end
        end else begin
            presc_d = presc_q + PW'(1);
        end
    end

    // A digit is a leading zero when it and every more significant nibble
    // are zero; digit 0 always stays lit so a zero value still shows "0".
    always_comb begin
        frame_shifted = frame_q >> {idx_q, 2'b00};
        cur_nibble    = frame_shifted[3:0];
        cur_blank     = BLANK_LEADING && (idx_q != 3'd0) && (frame_shifted == 32'd0);
        an_d          = 8'hFF;
        seg_d         = 8'hFF;
        if (!cur_blank) begin
            an_d  = ~(8'd1 << idx_q);
            // The dp on digit 4 marks the addr/data split of op 110.
            seg_d = {~(frame_dp_q && (idx_q == 3'd4)), hex_to_seg(cur_nibble)};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            presc_q    <= '0;
            idx_q      <= 3'd0;
            frame_q    <= 32'd0;
            frame_dp_q <= 1'b0;
            op_q       <= 3'd0;
            an_q       <= 8'hFF;
            seg_q      <= 8'hFF;
        end else begin
            presc_q    <= presc_d;
            idx_q      <= idx_d;
            frame_q    <= frame_d;
            frame_dp_q <= frame_dp_d;
            op_q       <= display_op;
            an_q       <= an_d;
            seg_q      <= seg_d;
        end
    end

    assign an  = an_q;
    assign seg = seg_q;

endmodule
